uart_rx: RTL and testbench

- UART receive stage that sits between the 16x-oversampling baud tick generator and the command/data logic inside the top-level UART.
- Synchronises the serial `rx` line and detects and validates the start bit.
- Samples each data bit at mid-bit, checks the stop bit, and presents one received byte per frame with a single-cycle done strobe and a framing-error flag.

---
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 2-flop rx synchroniser, oversampled start/data/stop FSM, framing check
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int OVS     = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            busy
);

  localparam int TMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int TW   = $clog2(TMAX);
  localparam int BW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [TW-1:0] T_MID  = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] T_BIT  = TW'(OVS - 1);
  localparam logic [TW-1:0] T_STOP = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DBIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t            r_state, w_state_n;
  logic [TW-1:0]     r_tick, w_tick_n;
  logic [BW-1:0]     r_bitc, w_bitc_n;
  logic [DBIT-1:0]   r_shreg, w_shreg_n;
  logic [DBIT-1:0]   r_dout, w_dout_n;
  logic              r_done, w_done_n;
  logic              r_ferr, w_ferr_n;
  logic              r_rx_meta, r_rx_s;

  // Synchroniser flops preset to the idle line level so reset never looks like a start bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bitc  <= '0;
      r_shreg <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_tick  <= w_tick_n;
      r_bitc  <= w_bitc_n;
      r_shreg <= w_shreg_n;
      r_dout  <= w_dout_n;
      r_done  <= w_done_n;
      r_ferr  <= w_ferr_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_tick_n  = r_tick;
    w_bitc_n  = r_bitc;
    w_shreg_n = r_shreg;
    w_dout_n  = r_dout;
    w_done_n  = 1'b0;
    w_ferr_n  = r_ferr;
    unique case (r_state)
      S_IDLE: begin
        if (!r_rx_s) w_state_n = S_START;
      end
      S_START: begin
        if (s_tick) begin
          if (r_tick == T_MID) begin
            w_state_n = r_rx_s ? S_IDLE : S_DATA;
            w_bitc_n  = '0;
          end else begin
            w_tick_n = r_tick + TW'(1);
          end
        end
      end
      S_DATA: begin
        if (s_tick) begin
          if (r_tick == T_BIT) begin
            w_tick_n  = '0;
            w_shreg_n = {r_rx_s, r_shreg[DBIT-1:1]};
            if (r_bitc == B_LAST) w_state_n = S_STOP;
            else                  w_bitc_n  = r_bitc + BW'(1);
          end else begin
            w_tick_n = r_tick + TW'(1);
          end
        end
      end
      S_STOP: begin
        if (s_tick) begin
          if (r_tick == T_STOP) begin
            w_dout_n  = r_shreg;
            w_done_n  = 1'b1;
            w_ferr_n  = ~r_rx_s;
            w_state_n = r_rx_s ? S_IDLE : S_BREAK;
          end else begin
            w_tick_n = r_tick + TW'(1);
          end
        end
      end
      S_BREAK: begin
        // A held-low line yields one errored frame, then waits for the line to recover
        if (r_rx_s) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
    if (w_state_n != r_state) w_tick_n = '0;
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (s_tick every 4 clk, 64 clk per bit)
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       s_tick = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       busy;

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  int dbl_cnt = 0;
  int busy_gap = 0;
  logic prev_done = 1'b0;
  logic expect_busy = 1'b0;
  int base;

  uart_rx #(.DBIT(8), .SB_TICK(16), .OVS(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
    .dout(dout), .rx_done_tick(rx_done_tick), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  always @(posedge clk) begin
    prev_done <= rx_done_tick;
    if (rx_done_tick) done_cnt <= done_cnt + 1;
    if (rx_done_tick && prev_done) dbl_cnt <= dbl_cnt + 1;
    if (expect_busy && !busy) busy_gap <= busy_gap + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    if (glitch) begin
      rx = ~b;
      clks(8);
      rx = b;
      clks(56);
    end else begin
      rx = b;
      clks(64);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic glitch);
    rx = 1'b0;
    clks(8);
    expect_busy = 1'b1;
    clks(56);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
    expect_busy = 1'b0;
    send_bit(stop, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    rx = 1'b1;
    for (int i = 0; i < 10; i++) begin
      clks(1);
      rx = ~rx;
    end
    check("rst_dout", {24'd0, dout}, 32'h00);
    check("rst_done", {31'd0, rx_done_tick}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    clks(2);
    reset = 1'b1;
    clks(50);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_nodone", done_cnt, 0);

    send_frame(8'h55, 1'b1, 1'b0);
    clks(10);
    check("f55_cnt", done_cnt, 1);
    check("f55_dout", {24'd0, dout}, 32'h55);
    check("f55_ferr", {31'd0, frame_err}, 32'd0);
    check("f55_busygap", busy_gap, 0);

    send_frame(8'hA3, 1'b1, 1'b0);
    check("bb1_cnt", done_cnt, 2);
    check("bb1_dout", {24'd0, dout}, 32'hA3);
    send_frame(8'h0F, 1'b1, 1'b1);
    clks(10);
    check("bb2_cnt", done_cnt, 3);
    check("bb2_dout", {24'd0, dout}, 32'h0F);
    check("bb2_ferr", {31'd0, frame_err}, 32'd0);
    check("bb_busygap", busy_gap, 0);

    base = done_cnt;
    rx = 1'b0;
    clks(20);
    rx = 1'b1;
    clks(80);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_nodone", done_cnt, base);
    check("glitch_dout", {24'd0, dout}, 32'h0F);

    base = done_cnt;
    send_frame(8'hC4, 1'b0, 1'b0);
    rx = 1'b0;
    clks(160);
    check("fe_cnt", done_cnt, base + 1);
    check("fe_dout", {24'd0, dout}, 32'hC4);
    check("fe_ferr", {31'd0, frame_err}, 32'd1);
    check("fe_break_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    clks(64);
    check("fe_recover_busy", {31'd0, busy}, 32'd0);
    check("fe_single", done_cnt, base + 1);
    send_frame(8'h7E, 1'b1, 1'b0);
    clks(10);
    check("f7e_dout", {24'd0, dout}, 32'h7E);
    check("f7e_ferr", {31'd0, frame_err}, 32'd0);
    check("f7e_cnt", done_cnt, base + 2);

    rx = 1'b0;
    clks(64);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    clks(20);
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_dout", {24'd0, dout}, 32'h00);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
    rx = 1'b1;
    clks(5);
    reset = 1'b1;
    clks(64);
    base = done_cnt;
    send_frame(8'h12, 1'b1, 1'b0);
    clks(10);
    check("f12_dout", {24'd0, dout}, 32'h12);
    check("f12_ferr", {31'd0, frame_err}, 32'd0);
    check("f12_cnt", done_cnt, base + 1);
    check("no_double_strobe", dbl_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
